// File: rtl/pipeline_register_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_register_if
//  Description : Load/data bundle for one pipeline_register stage.
//                master drives the load enable and the word to capture.
//                slave (the register) returns its registered contents.
//  Signals     : enable   - load enable, active-high
//                data_in  - WIDTH-bit word to capture
//                data_out - WIDTH-bit registered contents
//  Revision    : 1.0  initial release
// ============================================================================
interface pipeline_register_if #(
    parameter int WIDTH = 8
) ();
    logic             enable;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;

    modport master (
        output enable,
        output data_in,
        input  data_out
    );

    modport slave (
        input  enable,
        input  data_in,
        output data_out
    );
endinterface : pipeline_register_if
`default_nettype wire

// File: rtl/pipeline_register.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_register
//  Description : Clock-enabled WIDTH-bit data register with a synchronous,
//                active-high reset to RESET_VALUE. It is the basic storage
//                element of the skid-buffer datapath. data_out comes
//                straight from the flops, so no input reaches it
//                combinationally.
//  Ports       : clk  - the only clock, rising edge
//                rst  - synchronous reset, active-high, beats enable
//                bus  - slave side of pipeline_register_if
//                       (enable, data_in in; data_out out)
//  Parameters  : WIDTH       - data width, 1 or more. It must match the
//                              WIDTH of the connected interface.
//                RESET_VALUE - reset contents. The value is truncated or
//                              zero-extended to WIDTH bits.
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_register #(
    parameter int WIDTH       = 8,
    parameter     RESET_VALUE = 0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    pipeline_register_if.slave bus
);

    // The sized cast performs the truncation or zero-extension to WIDTH.
    localparam logic [WIDTH-1:0] C_RESET_VALUE = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] r_data;

    // Reset takes priority over a load. Without reset or enable the
    // register holds its value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= C_RESET_VALUE;
        end else if (bus.enable) begin
            r_data <= bus.data_in;
        end
    end

    assign bus.data_out = r_data;

endmodule : pipeline_register
`default_nettype wire

// File: tb/tb_pipeline_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_register
//  Description : Scoreboard bench for pipeline_register. It drives four
//                instances (W4/RV0, W4/RVA, W1/RV1, W32/RVDEADBEEF) from
//                one shared stimulus stream. A reference model pushes the
//                expected post-edge contents into a queue. A separate
//                monitor pops the queue and compares after each rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_register;

    localparam logic [31:0] C_RV32 = 32'hDEADBEEF;

    typedef struct {
        logic [3:0]  w4a;
        logic [3:0]  w4b;
        logic        w1;
        logic [31:0] w32;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] din;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];

    // Reference state: contents are unknown until the first reset edge.
    exp_t model;
    bit   model_known = 0;

    pipeline_register_if #(.WIDTH(4))  bus4a ();
    pipeline_register_if #(.WIDTH(4))  bus4b ();
    pipeline_register_if #(.WIDTH(1))  bus1  ();
    pipeline_register_if #(.WIDTH(32)) bus32 ();

    assign bus4a.enable  = enable;
    assign bus4a.data_in = din[3:0];
    assign bus4b.enable  = enable;
    assign bus4b.data_in = din[3:0];
    assign bus1.enable   = enable;
    assign bus1.data_in  = din[0];
    assign bus32.enable  = enable;
    assign bus32.data_in = din;

    pipeline_register #(.WIDTH(4),  .RESET_VALUE(0))      u_w4a (.clk(clk), .rst(rst), .bus(bus4a.slave));
    pipeline_register #(.WIDTH(4),  .RESET_VALUE(4'hA))   u_w4b (.clk(clk), .rst(rst), .bus(bus4b.slave));
    pipeline_register #(.WIDTH(1),  .RESET_VALUE(1))      u_w1  (.clk(clk), .rst(rst), .bus(bus1.slave));
    pipeline_register #(.WIDTH(32), .RESET_VALUE(C_RV32)) u_w32 (.clk(clk), .rst(rst), .bus(bus32.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record the rule for the upcoming edge. Reset gives each instance its
    // own reset value, a load copies the low bits of din, and otherwise
    // the contents hold.
    task automatic predict(input logic r, input logic e, input logic [31:0] d);
        if (r) begin
            model.w4a   = 4'h0;
            model.w4b   = 4'hA;
            model.w1    = 1'b1;
            model.w32   = C_RV32;
            model_known = 1;
        end else if (e) begin
            model.w4a = d[3:0];
            model.w4b = d[3:0];
            model.w1  = d[0];
            model.w32 = d;
        end
        if (model_known) exp_q.push_back(model);
    endtask

    // Inputs change on the falling edge, well away from the sampling edge.
    task automatic drive(input logic r, input logic e, input logic [31:0] d);
        @(negedge clk);
        rst    = r;
        enable = e;
        din    = d;
        predict(r, e, d);
    endtask

    // Pulse rst between edges only. The next edge sees rst=0 and a hold.
    task automatic pulse_rst_between_edges();
        @(negedge clk);
        enable = 1'b0;
        din    = 32'h0000_0003;
        rst    = 1'b1;
        #2;
        rst    = 1'b0;
        predict(1'b0, 1'b0, din);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: the register presents a fresh value after every rising edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("w4_rv0",  {28'h0, bus4a.data_out}, {28'h0, e.w4a});
                check("w4_rvA",  {28'h0, bus4b.data_out}, {28'h0, e.w4b});
                check("w1_rv1",  {31'h0, bus1.data_out},  {31'h0, e.w1});
                check("w32_rv",  bus32.data_out,          e.w32);
            end
        end
    end

    initial begin : stimulus
        rst    = 1'b0;
        enable = 1'b0;
        din    = 32'h0;

        // Power-up reset with enable low
        drive(1'b1, 1'b0, 32'h0000_000F);

        // Count sweep, including the all-ones word
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, i);

        // Hold 5 while data_in=C for 3 edges, then load C
        drive(1'b0, 1'b1, 32'h0000_0005);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'h0000_000C);
        drive(1'b0, 1'b1, 32'h0000_000C);

        // Reset wins over a simultaneous load
        drive(1'b0, 1'b1, 32'h0000_0009);
        drive(1'b1, 1'b1, 32'h0000_0003);

        // A reset pulse between edges has no effect
        drive(1'b0, 1'b1, 32'h0000_0007);
        pulse_rst_between_edges();
        drive(1'b0, 1'b0, 32'h0000_0000);

        // Width corners: alternating patterns, reset, all ones, all zeros
        drive(1'b0, 1'b1, 32'hA5A5_A5A5);
        drive(1'b0, 1'b1, 32'h5A5A_5A5A);
        drive(1'b1, 1'b0, 32'hFFFF_FFFF);
        drive(1'b0, 1'b1, 32'hFFFF_FFFF);
        drive(1'b0, 1'b0, 32'h0000_0000);
        drive(1'b0, 1'b1, 32'h0000_0000);
        drive(1'b0, 1'b1, 32'hFFFF_FFFE);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, $urandom);
        end

        // Let the monitor drain the queue, with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipeline_register
`default_nettype wire
